// File: rtl/sd_pkg.sv
// Shared SD CMD-line definitions used by both the host controller and the
// card-side responder.
//   resp_type_t    : response kind requested by card-emulation logic
//   *_FRAME_LEN    : bit lengths of short (48) and long (136) frames
//   RESP_*_RSVD    : all-ones fields used where R2/R3 carry no index/CRC
//   crc7_step      : one bit of the CMD-line CRC7 (x^7 + x^3 + 1)
//   crc7_40/120    : CRC7 over a 40- or 120-bit MSB-first field, initial 0
package sd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE      = 2'd0,
    RESP_R48       = 2'd1,
    RESP_R48_NOCRC = 2'd2,
    RESP_R136      = 2'd3
  } resp_type_t;

  localparam int unsigned CMD_FRAME_LEN  = 48;
  localparam int unsigned LONG_FRAME_LEN = 136;

  localparam logic [5:0] RESP_IDX_RSVD = 6'h3F;
  localparam logic [6:0] RESP_CRC_RSVD = 7'h7F;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] data);
    logic [6:0] crc;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      crc = crc7_step(crc, data[i]);
    end
    crc7_40 = crc;
  endfunction

  function automatic logic [6:0] crc7_120(input logic [119:0] data);
    logic [6:0] crc;
    crc = 7'd0;
    for (int i = 119; i >= 0; i--) begin
      crc = crc7_step(crc, data[i]);
    end
    crc7_120 = crc;
  endfunction

endpackage

// File: rtl/sd_clk_edge.sv
// Brings the host sdclk and the CMD pad into the clk domain and produces
// one-clk rise/fall event pulses from the synchronised sdclk.
//   clk, rst_n : system clock, async active-low reset
//   sdclk_i    : host SD clock (asynchronous)
//   cmd_i      : CMD pad input (asynchronous)
//   cmd_o      : synchronised CMD level, aligned with the edge pulses
//   rise_o     : one-clk pulse per synchronised sdclk rising edge
//   fall_o     : one-clk pulse per synchronised sdclk falling edge
module sd_clk_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sdclk_i,
  input  logic cmd_i,
  output logic cmd_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] first sync stage, [1] second sync stage, [2] previous value of [1]
  logic [2:0] sclk_q;
  logic [1:0] cmd_q;

  // Synchroniser chains; CMD resets to the idle-high line level so no
  // start bit is seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      cmd_q  <= 2'b11;
    end else begin
      sclk_q <= {sclk_q[1:0], sdclk_i};
      cmd_q  <= {cmd_q[0], cmd_i};
    end
  end

  // Edge pulses are decoded combinationally from registered stages so the
  // FSM can react in the same cycle, keeping pad latency within 3 clk.
  assign rise_o = sclk_q[1] & ~sclk_q[2];
  assign fall_o = ~sclk_q[1] & sclk_q[2];
  assign cmd_o  = cmd_q[1];

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD-line responder. Deserialises 48-bit host commands
// sampled on sdclk rises, checks framing and CRC7, presents the command to
// card-emulation logic and serialises the requested reply on sdclk falls.
//   NCR                  : idle sdclk periods between command and reply
//   clk, rst_n           : system clock, async active-low reset
//   sdclk, sdcmdin       : host clock and CMD pad input (asynchronous)
//   sdcmdoe, sdcmdout    : CMD pad output enable / value
//   busy                 : a frame exchange is in progress
//   cmd_valid/cmd/arg/cmd_err : received command, pulse-qualified
//   resp_ready/resp_valid: reply handshake
//   resp_type/cmd/arg/long    : reply request fields
module sd_cmd_responder
  import sd_pkg::*;
#(
  parameter int unsigned NCR = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sdclk,
  input  logic         sdcmdin,
  output logic         sdcmdoe,
  output logic         sdcmdout,
  output logic         busy,
  output logic         cmd_valid,
  output logic [5:0]   cmd,
  output logic [31:0]  arg,
  output logic         cmd_err,
  output logic         resp_ready,
  input  logic         resp_valid,
  input  logic [1:0]   resp_type,
  input  logic [5:0]   resp_cmd,
  input  logic [31:0]  resp_arg,
  input  logic [127:0] resp_long
);

  localparam logic [6:0] NCR_W    = 7'(NCR);
  localparam logic [5:0] RX_LAST  = 6'(CMD_FRAME_LEN - 1);
  localparam logic [7:0] LEN_S    = 8'(CMD_FRAME_LEN);
  localparam logic [7:0] LEN_L    = 8'(LONG_FRAME_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CMDOUT,
    ST_WAITRESP,
    ST_GAP,
    ST_SEND,
    ST_TAIL
  } state_t;

  logic cmd_s;
  logic rise_s;
  logic fall_s;

  state_t       state_q;
  logic [45:0]  rx_q;        // frame bits received after the start bit
  logic [5:0]   rx_cnt_q;    // bits still to receive, counting down to 1
  logic [6:0]   rx_crc_q;
  logic [6:0]   gap_q;       // rises seen since CMDOUT, saturating at NCR
  logic [135:0] tx_q;        // reply frame, left-aligned, shifted out MSB first
  logic [7:0]   tx_len_q;
  logic [7:0]   tx_cnt_q;    // bits still to drive after the current one
  logic         oe_q;
  logic         out_q;
  logic         busy_q;
  logic         cmd_valid_q;
  logic [5:0]   cmd_q;
  logic [31:0]  arg_q;
  logic         cmd_err_q;
  logic         resp_ready_q;

  logic [46:0]  rx_frame_s;
  logic         rx_err_s;
  logic [135:0] tx_frame_s;
  logic [7:0]   tx_len_s;
  logic         unused_long_s;

  sd_clk_edge u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .sdclk_i (sdclk),
    .cmd_i   (sdcmdin),
    .cmd_o   (cmd_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  // The low byte of the long payload is replaced by CRC and end bit.
  assign unused_long_s = ^resp_long[7:0];

  // Completed frame (bits 46..0) as it stands on the stop-bit rise, with
  // the framing/CRC verdict for that frame.
  always_comb begin
    rx_frame_s = {rx_q, cmd_s};
    rx_err_s   = (rx_crc_q != rx_frame_s[7:1]) | ~rx_frame_s[46] | ~rx_frame_s[0];
  end

  // Reply frame assembly from the request fields, left-aligned in 136 bits.
  always_comb begin
    tx_frame_s = 136'd0;
    tx_len_s   = LEN_S;
    case (resp_type_t'(resp_type))
      RESP_R48: begin
        tx_frame_s = {2'b00, resp_cmd, resp_arg,
                      crc7_40({2'b00, resp_cmd, resp_arg}), 1'b1, 88'd0};
        tx_len_s   = LEN_S;
      end
      RESP_R48_NOCRC: begin
        tx_frame_s = {2'b00, RESP_IDX_RSVD, resp_arg, RESP_CRC_RSVD, 1'b1, 88'd0};
        tx_len_s   = LEN_S;
      end
      RESP_R136: begin
        tx_frame_s = {2'b00, RESP_IDX_RSVD, resp_long[127:8],
                      crc7_120(resp_long[127:8]), 1'b1};
        tx_len_s   = LEN_L;
      end
      default: begin
        tx_frame_s = 136'd0;
        tx_len_s   = LEN_S;
      end
    endcase
  end

  // Responder FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rx_q         <= 46'd0;
      rx_cnt_q     <= 6'd0;
      rx_crc_q     <= 7'd0;
      gap_q        <= 7'd0;
      tx_q         <= 136'd0;
      tx_len_q     <= 8'd0;
      tx_cnt_q     <= 8'd0;
      oe_q         <= 1'b0;
      out_q        <= 1'b1;
      busy_q       <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= 6'd0;
      arg_q        <= 32'd0;
      cmd_err_q    <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise_s && !cmd_s) begin
            state_q  <= ST_RECV;
            busy_q   <= 1'b1;
            rx_q     <= 46'd0;
            rx_cnt_q <= RX_LAST;
            rx_crc_q <= crc7_step(7'd0, cmd_s);
          end
        end
        ST_RECV: begin
          if (rise_s) begin
            rx_q     <= rx_frame_s[45:0];
            rx_cnt_q <= rx_cnt_q - 6'd1;
            // Bit index is rx_cnt_q-1; only bits 47..8 feed the CRC.
            if (rx_cnt_q >= 6'd9) begin
              rx_crc_q <= crc7_step(rx_crc_q, cmd_s);
            end
            if (rx_cnt_q == 6'd1) begin
              state_q     <= ST_CMDOUT;
              cmd_valid_q <= 1'b1;
              cmd_q       <= rx_frame_s[45:40];
              arg_q       <= rx_frame_s[39:8];
              cmd_err_q   <= rx_err_s;
            end
          end
        end
        ST_CMDOUT: begin
          gap_q <= 7'd0;
          if (cmd_err_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q      <= ST_WAITRESP;
            resp_ready_q <= 1'b1;
          end
        end
        ST_WAITRESP: begin
          if (rise_s && (gap_q < NCR_W)) begin
            gap_q <= gap_q + 7'd1;
          end
          if (resp_valid && resp_ready_q) begin
            resp_ready_q <= 1'b0;
            if (resp_type_t'(resp_type) == RESP_NONE) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= ST_GAP;
              tx_q     <= tx_frame_s;
              tx_len_q <= tx_len_s;
            end
          end
        end
        ST_GAP: begin
          if (rise_s && (gap_q < NCR_W)) begin
            gap_q <= gap_q + 7'd1;
          end
          // Start bit goes out on the first fall once NCR idle rises passed.
          if (fall_s && (gap_q >= NCR_W)) begin
            state_q  <= ST_SEND;
            oe_q     <= 1'b1;
            out_q    <= tx_q[135];
            tx_q     <= {tx_q[134:0], 1'b0};
            tx_cnt_q <= tx_len_q - 8'd1;
          end
        end
        ST_SEND: begin
          if (fall_s) begin
            if (tx_cnt_q == 8'd0) begin
              state_q <= ST_TAIL;
              out_q   <= 1'b1;
            end else begin
              out_q    <= tx_q[135];
              tx_q     <= {tx_q[134:0], 1'b0};
              tx_cnt_q <= tx_cnt_q - 8'd1;
            end
          end
        end
        ST_TAIL: begin
          if (fall_s) begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          oe_q         <= 1'b0;
          out_q        <= 1'b1;
          busy_q       <= 1'b0;
          resp_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign sdcmdoe    = oe_q;
  assign sdcmdout   = out_q;
  assign busy       = busy_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd        = cmd_q;
  assign arg        = arg_q;
  assign cmd_err    = cmd_err_q;
  assign resp_ready = resp_ready_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
module tb_sd_cmd_responder;

  localparam int unsigned NCR = 2;

  logic         clk;
  logic         rst_n;
  logic         sdclk;
  logic         sdcmdin;
  logic         sdcmdoe;
  logic         sdcmdout;
  logic         busy;
  logic         cmd_valid;
  logic [5:0]   cmd;
  logic [31:0]  arg;
  logic         cmd_err;
  logic         resp_ready;
  logic         resp_valid;
  logic [1:0]   resp_type;
  logic [5:0]   resp_cmd;
  logic [31:0]  resp_arg;
  logic [127:0] resp_long;

  logic host_oe;
  logic host_out;

  int checks;
  int failures;
  int oe_rises;
  logic oe_prev;

  // scoreboards: {cmd, arg, err} and {len, frame bits}
  logic [38:0]  cmd_exp_q[$];
  logic [38:0]  cmd_obs_q[$];
  logic [143:0] rsp_exp_q[$];

  sd_cmd_responder #(.NCR(NCR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sdclk      (sdclk),
    .sdcmdin    (sdcmdin),
    .sdcmdoe    (sdcmdoe),
    .sdcmdout   (sdcmdout),
    .busy       (busy),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .arg        (arg),
    .cmd_err    (cmd_err),
    .resp_ready (resp_ready),
    .resp_valid (resp_valid),
    .resp_type  (resp_type),
    .resp_cmd   (resp_cmd),
    .resp_arg   (resp_arg),
    .resp_long  (resp_long)
  );

  // open-drain style line with pull-up
  assign sdcmdin = host_oe ? host_out : (sdcmdoe ? sdcmdout : 1'b1);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sdclk phases of 50 time units (5 clk), edges never coincide with clk edges
  initial begin
    sdclk = 1'b0;
    #3;
    forever #50 sdclk = ~sdclk;
  end

  always @(negedge clk) begin
    if (cmd_valid) cmd_obs_q.push_back({cmd, arg, cmd_err});
  end

  always @(negedge clk) begin
    if (sdcmdoe && !oe_prev) oe_rises <= oe_rises + 1;
    oe_prev <= sdcmdoe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] tb_crc7(input logic [119:0] d, input int n);
    logic [6:0] c;
    logic fb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'b0001001;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] a);
    logic [39:0] h;
    h = {2'b01, idx, a};
    return {h, tb_crc7({80'd0, h}, 40), 1'b1};
  endfunction

  task automatic host_send(input logic [47:0] f);
    @(negedge sdclk);
    host_oe = 1'b1;
    for (int i = 47; i >= 0; i--) begin
      host_out = f[i];
      @(negedge sdclk);
    end
    host_oe  = 1'b0;
    host_out = 1'b1;
  endtask

  // n = number of host rises up to and including the one that saw the start bit
  task automatic host_recv(input int len, input int limit, output logic [135:0] bits,
                           output bit got, output int n);
    bits = '0;
    got  = 1'b0;
    n    = 0;
    while (!got && n < limit) begin
      @(posedge sdclk);
      n++;
      if (sdcmdin === 1'b0) got = 1'b1;
    end
    if (got) begin
      for (int i = len - 2; i >= 0; i--) begin
        @(posedge sdclk);
        bits[i] = sdcmdin;
      end
    end
  endtask

  task automatic get_cmd(output logic [38:0] exp, output logic [38:0] obs);
    exp = cmd_exp_q.size() != 0 ? cmd_exp_q.pop_front() : 39'd0;
    obs = 'x;
    for (int i = 0; i < 40 && cmd_obs_q.size() == 0; i++) @(posedge clk);
    if (cmd_obs_q.size() != 0) obs = cmd_obs_q.pop_front();
  endtask

  task automatic test_reset();
    logic [42:0] obs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {sdcmdoe, sdcmdout, busy, cmd_valid, cmd, arg, cmd_err, resp_ready};
    checks++;
    if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_cmd0_none();
    logic [38:0] e, o;
    resp_type  = 2'd0;
    resp_valid = 1'b1;
    oe_rises   = 0;
    cmd_exp_q.push_back({6'd0, 32'd0, 1'b0});
    host_send(48'h40_0000_0000_95);
    get_cmd(e, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL cmd0_decode: got %h expected %h", o, e);
    end
    repeat (20) @(posedge sdclk);
    checks++;
    if (oe_rises !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cmd0_no_reply: oe_rises=%0d busy=%b expected 0 0", oe_rises, busy);
    end
  endtask

  task automatic test_cmd8_r1();
    logic [38:0] e, o;
    logic [135:0] bits;
    logic [143:0] ex;
    logic [39:0] h;
    bit got;
    int n;
    resp_type  = 2'd1;
    resp_cmd   = 6'd8;
    resp_arg   = 32'h0000_01AA;
    resp_valid = 1'b1;
    oe_rises   = 0;
    h = {2'b00, 6'd8, 32'h0000_01AA};
    cmd_exp_q.push_back({6'd8, 32'h0000_01AA, 1'b0});
    rsp_exp_q.push_back({8'd48, 88'd0, h, tb_crc7({80'd0, h}, 40), 1'b1});
    host_send(48'h48_0000_01AA_87);
    get_cmd(e, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL cmd8_decode: got %h expected %h", o, e);
    end
    host_recv(48, 999, bits, got, n);
    ex = rsp_exp_q.pop_front();
    checks++;
    if (!got || n !== NCR + 1) begin
      failures++;
      $display("FAIL cmd8_ncr: got=%0d start at rise %0d expected rise %0d", got, n, NCR + 1);
    end
    checks++;
    if (bits[47:0] !== ex[47:0]) begin
      failures++;
      $display("FAIL cmd8_r1_frame: got %h expected %h", bits[47:0], ex[47:0]);
    end
    checks++;
    if (bits[39:8] !== 32'h0000_01AA || bits[46] !== 1'b0 || bits[0] !== 1'b1) begin
      failures++;
      $display("FAIL cmd8_host_done: resparg=%h tx=%b end=%b expected 000001aa 0 1", bits[39:8], bits[46], bits[0]);
    end
    repeat (3) @(posedge sdclk);
    checks++;
    if (sdcmdoe !== 1'b0 || busy !== 1'b0 || oe_rises !== 1) begin
      failures++;
      $display("FAIL cmd8_release: oe=%b busy=%b oe_rises=%0d expected 0 0 1", sdcmdoe, busy, oe_rises);
    end
  endtask

  task automatic test_crc_err();
    logic [38:0] e, o;
    logic [135:0] bits;
    bit got;
    int n;
    resp_type  = 2'd1;
    resp_valid = 1'b1;
    oe_rises   = 0;
    cmd_exp_q.push_back({6'd0, 32'd1, 1'b1});
    host_send(48'h40_0000_0001_95);
    get_cmd(e, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL crcerr_decode: got %h expected %h", o, e);
    end
    host_recv(48, 80, bits, got, n);
    checks++;
    if (got || oe_rises !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL crcerr_no_reply: start_seen=%0d oe_rises=%0d busy=%b expected 0 0 0", got, oe_rises, busy);
    end
  endtask

  task automatic test_r2_long();
    logic [38:0] e, o;
    logic [135:0] bits;
    logic [143:0] ex;
    bit got;
    int n;
    resp_type  = 2'd3;
    resp_long  = 128'h0123456789ABCDEF_0123456789ABEF00;
    resp_valid = 1'b1;
    cmd_exp_q.push_back({6'd2, 32'd0, 1'b0});
    rsp_exp_q.push_back({8'd136, 2'b00, 6'h3F, resp_long[127:8], tb_crc7(resp_long[127:8], 120), 1'b1});
    host_send(make_frame(6'd2, 32'd0));
    get_cmd(e, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL cmd2_decode: got %h expected %h", o, e);
    end
    host_recv(136, 999, bits, got, n);
    ex = rsp_exp_q.pop_front();
    checks++;
    if (!got || bits[135:120] !== 16'h3F01 || bits[127:8] !== ex[127:8]) begin
      failures++;
      $display("FAIL r2_payload: got=%0d head=%h payload=%h expected %h", got, bits[135:128], bits[127:8], ex[127:8]);
    end
    checks++;
    if (bits[7:1] !== ex[7:1]) begin
      failures++;
      $display("FAIL r2_crc: got %h expected %h", bits[7:1], ex[7:1]);
    end
    checks++;
    if (bits[0] !== 1'b1) begin
      failures++;
      $display("FAIL r2_end_bit: got %b expected 1", bits[0]);
    end
    repeat (3) @(posedge sdclk);
  endtask

  task automatic test_r3();
    logic [38:0] e, o;
    logic [135:0] bits;
    logic [143:0] ex;
    bit got;
    int n;
    resp_type  = 2'd2;
    resp_arg   = 32'h80FF_8000;
    resp_valid = 1'b1;
    cmd_exp_q.push_back({6'd41, 32'h4000_0000, 1'b0});
    rsp_exp_q.push_back({8'd48, 88'd0, 48'h3F_80FF8000_FF});
    host_send(make_frame(6'd41, 32'h4000_0000));
    get_cmd(e, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL cmd41_decode: got %h expected %h", o, e);
    end
    host_recv(48, 999, bits, got, n);
    ex = rsp_exp_q.pop_front();
    checks++;
    if (!got || bits[47:0] !== ex[47:0]) begin
      failures++;
      $display("FAIL r3_frame: got %h expected %h", bits[47:0], ex[47:0]);
    end
    repeat (3) @(posedge sdclk);
  endtask

  task automatic test_late_resp();
    logic [38:0] e, o;
    logic [135:0] bits;
    logic [143:0] ex;
    logic [39:0] h;
    bit got;
    int n;
    resp_valid = 1'b0;
    resp_type  = 2'd1;
    resp_cmd   = 6'd55;
    resp_arg   = 32'h0000_0120;
    h = {2'b00, 6'd55, 32'h0000_0120};
    cmd_exp_q.push_back({6'd55, 32'h1234_0000, 1'b0});
    rsp_exp_q.push_back({8'd48, 88'd0, h, tb_crc7({80'd0, h}, 40), 1'b1});
    host_send(make_frame(6'd55, 32'h1234_0000));
    get_cmd(e, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL cmd55_decode: got %h expected %h", o, e);
    end
    repeat (50) @(posedge sdclk);
    checks++;
    if (resp_ready !== 1'b1 || busy !== 1'b1 || sdcmdoe !== 1'b0) begin
      failures++;
      $display("FAIL late_wait: ready=%b busy=%b oe=%b expected 1 1 0", resp_ready, busy, sdcmdoe);
    end
    #1;
    resp_valid = 1'b1;
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    checks++;
    if (resp_ready !== 1'b0) begin
      failures++;
      $display("FAIL late_ready_drop: got %b expected 0", resp_ready);
    end
    host_recv(48, 999, bits, got, n);
    ex = rsp_exp_q.pop_front();
    checks++;
    if (!got || n !== 1) begin
      failures++;
      $display("FAIL late_start: got=%0d start at rise %0d expected rise 1", got, n);
    end
    checks++;
    if (bits[47:0] !== ex[47:0]) begin
      failures++;
      $display("FAIL late_frame: got %h expected %h", bits[47:0], ex[47:0]);
    end
    repeat (3) @(posedge sdclk);
  endtask

  task automatic test_reset_mid_send();
    logic [38:0] e, o;
    logic [3:0] obs;
    bit seen;
    resp_type  = 2'd3;
    resp_valid = 1'b1;
    cmd_exp_q.push_back({6'd2, 32'd0, 1'b0});
    host_send(make_frame(6'd2, 32'd0));
    get_cmd(e, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL rstmid_decode: got %h expected %h", o, e);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge sdclk);
      seen = (sdcmdoe === 1'b1);
    end
    repeat (20) @(posedge sdclk);
    #4;
    rst_n = 1'b0;
    #1;
    obs = {sdcmdoe, busy, sdcmdout, resp_ready};
    checks++;
    if (!seen || obs !== 4'b0010) begin
      failures++;
      $display("FAIL rstmid_release: send_seen=%0d oe,busy,out,ready=%b expected 0010", seen, obs);
    end
    #20;
    rst_n = 1'b1;
    resp_valid = 1'b0;
    repeat (5) @(posedge sdclk);
    checks++;
    if (sdcmdoe !== 1'b0 || busy !== 1'b0 || cmd_obs_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_idle: oe=%b busy=%b extra_cmds=%0d expected 0 0 0", sdcmdoe, busy, cmd_obs_q.size());
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    oe_rises   = 0;
    oe_prev    = 1'b0;
    rst_n      = 1'b0;
    host_oe    = 1'b0;
    host_out   = 1'b1;
    resp_valid = 1'b0;
    resp_type  = 2'd0;
    resp_cmd   = 6'd0;
    resp_arg   = 32'd0;
    resp_long  = 128'd0;
    test_reset();
    test_cmd0_none();
    test_cmd8_r1();
    test_crc_err();
    test_r2_long();
    test_r3();
    test_late_resp();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
